usb_device_responder: RTL and testbench

//  Device-side (function) end of the USB link: consumes decoded packets from the receive path and answers OUT/IN

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_ep_store.sv | 57 +++++
 rtl/usb_device_responder.sv | 118 +++++++++++
 tb/tb_usb_device_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared PID codes, packet layout and responder state encoding
package usb_pkg;

    localparam int PKT_W = 99;

    typedef enum logic [7:0] {
        PID_OUT   = 8'hE1,
        PID_IN    = 8'h69,
        PID_DATA0 = 8'hC3,
        PID_DATA1 = 8'h4B,
        PID_ACK   = 8'hD2,
        PID_NAK   = 8'h5A,
        PID_STALL = 8'h1E
    } pid_t;

    typedef struct packed {
        logic [7:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        logic [15:0] crc;
    } pkt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_SEND_HS,
        S_SEND_DATA,
        S_WAIT_ACK
    } state_t;

endpackage

// File: rtl/usb_ep_store.sv
// usb_ep_store: per-endpoint 64-bit buffer with valid and IN/OUT data toggle bits
module usb_ep_store
    import usb_pkg::*;
#(
    parameter int NUM_EP = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [3:0]  ep,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic        ack_en,
    output logic [63:0] rd_data,
    output logic [15:0] valid,
    output logic [15:0] in_tog,
    output logic [15:0] out_tog
);
    logic [63:0] mem [16];

    for (genvar i = 0; i < 16; i++) begin : g_ep
        if (i < NUM_EP) begin : g_on
            logic [63:0] q;
            logic        v, ti, to;
            // a write fills the buffer and advances the OUT toggle; a host ACK frees it and advances the IN toggle
            always_ff @(posedge clk) begin
                if (!rst_b) begin
                    q  <= '0;
                    v  <= 1'b0;
                    ti <= 1'b0;
                    to <= 1'b0;
                end else if (ep == 4'(i)) begin
                    if (wr_en) begin
                        q  <= wr_data;
                        v  <= 1'b1;
                        to <= ~to;
                    end
                    if (ack_en) begin
                        v  <= 1'b0;
                        ti <= ~ti;
                    end
                end
            end
            assign mem[i]     = q;
            assign valid[i]   = v;
            assign in_tog[i]  = ti;
            assign out_tog[i] = to;
        end else begin : g_off
            assign mem[i]     = '0;
            assign valid[i]   = 1'b0;
            assign in_tog[i]  = 1'b0;
            assign out_tog[i] = 1'b0;
        end
    end

    assign rd_data = mem[ep];

endmodule

// File: rtl/usb_device_responder.sv
// usb_device_responder: device-side USB transaction responder; define USB_DEV_STALL_EN to STALL unimplemented endpoints
module usb_device_responder
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'd5,
    parameter int         NUM_EP      = 4,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [PKT_W-1:0] rx_pkt,
    input  logic             rx_pkt_avail,
    input  logic             rx_data_good,
    output logic [PKT_W-1:0] tx_pkt,
    output logic             tx_pkt_avail,
    input  logic             tx_ready,
    output logic             re,
    output logic [15:0]      ep_valid
);
    localparam int         CW  = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [4:0] NEP = 5'(NUM_EP);
`ifdef USB_DEV_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    pkt_t        rx;
    state_t      state;
    logic [3:0]  ep;
    logic [7:0]  hs_pid;
    logic        stall;
    logic [CW-1:0] cnt;
    logic [63:0] rd_data;
    logic [15:0] in_tog, out_tog;
    logic [15:0] unused_crc;
    logic        good, is_data, is_tok, match, ep_ok, tog_ok, wr_en, ack_en, timed_out;

    assign rx         = pkt_t'(rx_pkt);
    assign unused_crc = rx.crc;
    assign good       = rx_pkt_avail && rx_data_good &&
                        (rx.pid inside {PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL});
    assign is_data    = rx.pid == PID_DATA0 || rx.pid == PID_DATA1;
    assign is_tok     = rx.pid == PID_OUT || rx.pid == PID_IN;
    assign match      = rx.addr == DEV_ADDR;
    assign ep_ok      = {1'b0, rx.endp} < NEP;
    assign tog_ok     = (rx.pid == PID_DATA1) == out_tog[ep];
    assign wr_en      = state == S_WAIT_DATA && good && is_data && !stall && tog_ok;
    assign ack_en     = state == S_WAIT_ACK && good && rx.pid == PID_ACK;
    assign timed_out  = cnt >= CW'(TIMEOUT_CYC - 1);

    usb_ep_store #(.NUM_EP(NUM_EP)) u_store (
        .clk     (clk),
        .rst_b   (rst_b),
        .ep      (ep),
        .wr_en   (wr_en),
        .wr_data (rx.data),
        .ack_en  (ack_en),
        .rd_data (rd_data),
        .valid   (ep_valid),
        .in_tog  (in_tog),
        .out_tog (out_tog)
    );

    // transaction FSM: decode tokens, collect OUT data, emit handshakes/IN data, await host ACK with timeout
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state        <= S_IDLE;
            ep           <= '0;
            hs_pid       <= '0;
            stall        <= 1'b0;
            cnt          <= '0;
            tx_pkt       <= '0;
            tx_pkt_avail <= 1'b0;
            re           <= 1'b1;
        end else begin
            tx_pkt_avail <= 1'b0;
            case (state)
                S_IDLE: if (good && match && is_tok && (ep_ok || STALL_EN)) begin
                    ep    <= rx.endp;
                    cnt   <= '0;
                    stall <= !ep_ok;
                    if (rx.pid == PID_OUT) begin
                        state <= S_WAIT_DATA;
                    end else begin
                        re     <= 1'b0;
                        hs_pid <= ep_ok ? PID_NAK : PID_STALL;
                        state  <= (ep_ok && ep_valid[rx.endp]) ? S_SEND_DATA : S_SEND_HS;
                    end
                end
                S_WAIT_DATA: if (good && is_data) begin
                    re     <= 1'b0;
                    hs_pid <= stall ? PID_STALL : PID_ACK;
                    state  <= S_SEND_HS;
                end else if ((good && is_tok) || timed_out) begin
                    state <= S_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_SEND_HS, S_SEND_DATA: if (tx_ready) begin
                    tx_pkt_avail <= 1'b1;
                    tx_pkt       <= (state == S_SEND_HS) ? {hs_pid, 91'd0} :
                                    {in_tog[ep] ? PID_DATA1 : PID_DATA0, 11'd0, rd_data, 16'd0};
                    re           <= 1'b1;
                    cnt          <= '0;
                    state        <= (state == S_SEND_HS) ? S_IDLE : S_WAIT_ACK;
                end
                S_WAIT_ACK: if (good || timed_out) begin
                    state <= S_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_device_responder.sv
// tb_usb_device_responder: directed scenarios for the USB device responder with hand-computed expectations
module tb_usb_device_responder;

    localparam logic [7:0] P_OUT   = 8'hE1;
    localparam logic [7:0] P_IN    = 8'h69;
    localparam logic [7:0] P_DATA0 = 8'hC3;
    localparam logic [7:0] P_DATA1 = 8'h4B;
    localparam logic [7:0] P_ACK   = 8'hD2;
    localparam logic [7:0] P_NAK   = 8'h5A;
    localparam logic [7:0] P_STALL = 8'h1E;
    localparam logic [63:0] D1 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] D4 = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [98:0] rx_pkt = '0;
    logic        rx_pkt_avail = 1'b0;
    logic        rx_data_good = 1'b0;
    logic [98:0] tx_pkt;
    logic        tx_pkt_avail;
    logic        tx_ready = 1'b1;
    logic        re;
    logic [15:0] ep_valid;

    int          checks = 0;
    int          errors = 0;
    int          tx_n = 0;
    logic [98:0] tx_last = '0;

    usb_device_responder dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .rx_pkt       (rx_pkt),
        .rx_pkt_avail (rx_pkt_avail),
        .rx_data_good (rx_data_good),
        .tx_pkt       (tx_pkt),
        .tx_pkt_avail (tx_pkt_avail),
        .tx_ready     (tx_ready),
        .re           (re),
        .ep_valid     (ep_valid)
    );

    always #5 clk = ~clk;

    // capture every response strobe
    always @(negedge clk) if (tx_pkt_avail === 1'b1) begin
        tx_n++;
        tx_last = tx_pkt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic send(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] e,
                        input logic [63:0] d, input logic g);
        @(negedge clk);
        rx_pkt       = {pid, a, e, d, 16'h0};
        rx_pkt_avail = 1'b1;
        rx_data_good = g;
        @(negedge clk);
        rx_pkt_avail = 1'b0;
        rx_data_good = 1'b0;
    endtask

    task automatic wait_tx(input int n0, input int maxc, output bit got);
        got = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk);
            if (tx_n != n0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_pkt_avail !== 1'b0) begin errors++; $display("FAIL reset_avail got %b exp 0", tx_pkt_avail); end
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL reset_re got %b exp 1", re); end
        checks++; if (ep_valid !== 16'h0) begin errors++; $display("FAIL reset_valid got %h exp 0000", ep_valid); end
        checks++; if (tx_pkt !== 99'd0) begin errors++; $display("FAIL reset_txpkt got %h exp 0", tx_pkt); end
        rst_b = 1'b1;
    endtask

    task automatic test_out_write;
        int n0; bit got;
        n0 = tx_n;
        send(P_OUT, 7'd5, 4'd1, 64'd0, 1'b1);
        send(P_DATA0, 7'd0, 4'd0, D1, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got) begin errors++; $display("FAIL out_ack_strobe got none exp strobe"); end
        checks++; if (tx_last[98:91] !== P_ACK) begin errors++; $display("FAIL out_ack_pid got %h exp %h", tx_last[98:91], P_ACK); end
        checks++; if (tx_last[90:0] !== 91'd0) begin errors++; $display("FAIL out_ack_fields got %h exp 0", tx_last[90:0]); end
        checks++; if (ep_valid !== 16'h0002) begin errors++; $display("FAIL out_valid got %h exp 0002", ep_valid); end
    endtask

    task automatic test_retransmit_and_in;
        int n0; bit got;
        n0 = tx_n;
        send(P_OUT, 7'd5, 4'd1, 64'd0, 1'b1);
        send(P_DATA0, 7'd0, 4'd0, D2, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_ACK) begin errors++; $display("FAIL retx_ack got %b/%h exp 1/%h", got, tx_last[98:91], P_ACK); end
        n0 = tx_n;
        send(P_IN, 7'd5, 4'd1, 64'd0, 1'b1);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL in_re_low got %b exp 0", re); end
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_DATA0) begin errors++; $display("FAIL in_pid got %b/%h exp 1/%h", got, tx_last[98:91], P_DATA0); end
        checks++; if (tx_last[79:16] !== D1) begin errors++; $display("FAIL in_data_unchanged got %h exp %h", tx_last[79:16], D1); end
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL in_re_back got %b exp 1", re); end
        n0 = tx_n;
        send(P_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        checks++; if (ep_valid !== 16'h0000) begin errors++; $display("FAIL ack_clears_valid got %h exp 0000", ep_valid); end
        idle(5);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL ack_silent got %0d exp %0d", tx_n, n0); end
        n0 = tx_n;
        send(P_OUT, 7'd5, 4'd1, 64'd0, 1'b1);
        send(P_DATA1, 7'd0, 4'd0, D3, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_ACK) begin errors++; $display("FAIL data1_ack got %b/%h exp 1/%h", got, tx_last[98:91], P_ACK); end
        checks++; if (ep_valid !== 16'h0002) begin errors++; $display("FAIL data1_valid got %h exp 0002", ep_valid); end
    endtask

    task automatic test_timeout;
        int n0; bit got;
        n0 = tx_n;
        send(P_IN, 7'd5, 4'd1, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_DATA1 || tx_last[79:16] !== D3) begin errors++; $display("FAIL in_toggle1 got %b/%h/%h exp 1/%h/%h", got, tx_last[98:91], tx_last[79:16], P_DATA1, D3); end
        n0 = tx_n;
        idle(270);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL timeout_silent got %0d exp %0d", tx_n, n0); end
        send(P_IN, 7'd5, 4'd1, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_DATA1 || tx_last[79:16] !== D3) begin errors++; $display("FAIL retry_resend got %b/%h/%h exp 1/%h/%h", got, tx_last[98:91], tx_last[79:16], P_DATA1, D3); end
        send(P_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        checks++; if (ep_valid !== 16'h0000) begin errors++; $display("FAIL retry_ack_valid got %h exp 0000", ep_valid); end
    endtask

    task automatic test_nak_and_addr;
        int n0; bit got;
        n0 = tx_n;
        send(P_IN, 7'd5, 4'd2, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last !== {P_NAK, 91'd0}) begin errors++; $display("FAIL nak got %b/%h exp 1/%h", got, tx_last, {P_NAK, 91'd0}); end
        n0 = tx_n;
        send(P_IN, 7'd6, 4'd1, 64'd0, 1'b1);
        idle(10);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL wrong_addr got %0d exp %0d", tx_n, n0); end
    endtask

    task automatic test_bad_crc;
        int n0; bit got;
        n0 = tx_n;
        send(P_OUT, 7'd5, 4'd1, 64'd0, 1'b1);
        send(P_DATA0, 7'd0, 4'd0, D4, 1'b0);
        idle(10);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL badcrc_silent got %0d exp %0d", tx_n, n0); end
        checks++; if (ep_valid !== 16'h0000) begin errors++; $display("FAIL badcrc_valid got %h exp 0000", ep_valid); end
        send(P_IN, 7'd5, 4'd1, 64'd0, 1'b1);
        idle(10);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL token_abort_silent got %0d exp %0d", tx_n, n0); end
        send(P_IN, 7'd5, 4'd1, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_NAK) begin errors++; $display("FAIL badcrc_nak got %b/%h exp 1/%h", got, tx_last[98:91], P_NAK); end
    endtask

    task automatic test_tx_ready;
        int n0; bit got;
        n0 = tx_n;
        tx_ready = 1'b0;
        send(P_OUT, 7'd5, 4'd3, 64'd0, 1'b1);
        send(P_DATA0, 7'd0, 4'd0, D5, 1'b1);
        idle(5);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL busy_hold got %0d exp %0d", tx_n, n0); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL busy_re got %b exp 0", re); end
        @(negedge clk);
        tx_ready = 1'b1;
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_ACK) begin errors++; $display("FAIL busy_ack got %b/%h exp 1/%h", got, tx_last[98:91], P_ACK); end
        checks++; if (ep_valid !== 16'h0008) begin errors++; $display("FAIL ep3_valid got %h exp 0008", ep_valid); end
    endtask

    task automatic test_stall;
        int n0; bit got;
        n0 = tx_n;
        send(P_IN, 7'd5, 4'd4, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
`ifdef USB_DEV_STALL_EN
        checks++; if (!got || tx_last !== {P_STALL, 91'd0}) begin errors++; $display("FAIL in_stall got %b/%h exp 1/%h", got, tx_last, {P_STALL, 91'd0}); end
`else
        checks++; if (got) begin errors++; $display("FAIL in_ep4_silent got strobe pid %h exp none", tx_last[98:91]); end
`endif
        n0 = tx_n;
        send(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
        send(P_DATA0, 7'd0, 4'd0, D4, 1'b1);
        wait_tx(n0, 10, got);
`ifdef USB_DEV_STALL_EN
        checks++; if (!got || tx_last[98:91] !== P_STALL) begin errors++; $display("FAIL out_stall got %b/%h exp 1/%h", got, tx_last[98:91], P_STALL); end
`else
        checks++; if (got) begin errors++; $display("FAIL out_ep4_silent got strobe pid %h exp none", tx_last[98:91]); end
`endif
        checks++; if (ep_valid !== 16'h0008) begin errors++; $display("FAIL ep4_no_write got %h exp 0008", ep_valid); end
    endtask

    task automatic test_reset_wait_ack;
        int n0; bit got;
        n0 = tx_n;
        send(P_IN, 7'd5, 4'd3, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_DATA0 || tx_last[79:16] !== D5) begin errors++; $display("FAIL ep3_in got %b/%h/%h exp 1/%h/%h", got, tx_last[98:91], tx_last[79:16], P_DATA0, D5); end
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (re !== 1'b1 || tx_pkt_avail !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got re=%b avail=%b exp re=1 avail=0", re, tx_pkt_avail); end
        checks++; if (tx_pkt !== 99'd0) begin errors++; $display("FAIL midrst_txpkt got %h exp 0", tx_pkt); end
        checks++; if (ep_valid !== 16'h0000) begin errors++; $display("FAIL midrst_valid got %h exp 0000", ep_valid); end
        rst_b = 1'b1;
        n0 = tx_n;
        send(P_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        idle(5);
        checks++; if (tx_n !== n0) begin errors++; $display("FAIL postrst_silent got %0d exp %0d", tx_n, n0); end
        send(P_IN, 7'd5, 4'd3, 64'd0, 1'b1);
        wait_tx(n0, 10, got);
        checks++; if (!got || tx_last[98:91] !== P_NAK) begin errors++; $display("FAIL postrst_nak got %b/%h exp 1/%h", got, tx_last[98:91], P_NAK); end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_retransmit_and_in();
        test_timeout();
        test_nak_and_addr();
        test_bad_crc();
        test_tx_ready();
        test_stall();
        test_reset_wait_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
